// File: rtl/serial_and8_collector.sv
// Serial-to-byte collector: shifts in 8 bits under valid/ready, then holds the
// byte and its all-ones flag until the downstream handshake or a clear.
module serial_and8_collector #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_word,
  output logic       out_and,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] bit_count
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t     state_q;
  logic [7:0] shreg_q;
  logic [7:0] shreg_d;
  logic [7:0] word_q;
  logic       and_q;
  logic [3:0] cnt_q;

  always_comb begin
    shreg_d = '0;
    if (MSB_FIRST) shreg_d = {shreg_q[6:0], in_bit};
    else           shreg_d = {in_bit, shreg_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      shreg_q <= '0;
      word_q  <= '0;
      and_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (clear) begin
      // Held word is dropped but out_word/out_and keep their last value.
      state_q <= COLLECT;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            shreg_q <= shreg_d;
            if (cnt_q == 4'd7) begin
              word_q  <= shreg_d;
              and_q   <= &shreg_d;
              cnt_q   <= 4'd8;
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_word  = word_q;
  assign out_and   = and_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_serial_and8_collector.sv
// Bench for serial_and8_collector: one MSB-first and one LSB-first instance,
// directed byte streams scored against hand-computed expected words.
module tb_serial_and8_collector;

  logic            clk = 1'b0;
  logic            reset, clear;
  logic [1:0]      in_bit, in_valid, in_ready, out_and, out_valid, out_ready;
  logic [1:0][7:0] ow;
  logic [1:0][3:0] bc;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];

  always #5 clk = ~clk;

  serial_and8_collector #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .clear(clear),
    .in_bit(in_bit[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_word(ow[0]), .out_and(out_and[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .bit_count(bc[0])
  );

  serial_and8_collector #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .clear(clear),
    .in_bit(in_bit[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_word(ow[1]), .out_and(out_and[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .bit_count(bc[1])
  );

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: a word is delivered on a clean out_valid & out_ready edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset && !clear && out_valid[0] && out_ready[0]) begin
      if (exp_q0.size() == 0) chk("msb_unexpected_delivery", {out_and[0], ow[0]}, 9'h1ff ^ {out_and[0], ow[0]});
      else begin
        e = exp_q0.pop_front();
        chk("msb_delivered_word", {out_and[0], ow[0]}, e);
      end
    end
    if (!reset && !clear && out_valid[1] && out_ready[1]) begin
      if (exp_q1.size() == 0) chk("lsb_unexpected_delivery", {out_and[1], ow[1]}, 9'h1ff ^ {out_and[1], ow[1]});
      else begin
        e = exp_q1.pop_front();
        chk("lsb_delivered_word", {out_and[1], ow[1]}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends seq[7] first; gaps holds 2 bits of idle-cycle count per bit.
  task automatic send_seq(input int sel, input logic [7:0] seq, input logic [15:0] gaps);
    for (int unsigned i = 0; i < 8; i++) begin
      repeat (int'((gaps >> (2 * i)) & 16'h3)) tick();
      in_valid[sel] = 1'b1;
      in_bit[sel]   = seq[7 - i];
      tick();
      in_valid[sel] = 1'b0;
      in_bit[sel]   = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    in_bit = '0; in_valid = '0; out_ready = '0;

    // T1 reset
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_out_valid", {8'h0, out_valid[0]}, 9'h0);
    chk("rst_out_word",  {1'b0, ow[0]}, 9'h000);
    chk("rst_out_and",   {8'h0, out_and[0]}, 9'h0);
    chk("rst_bit_count", {5'h0, bc[0]}, 9'h0);
    chk("rst_in_ready",  {8'h0, in_ready[0]}, 9'h1);

    // T2 MSB-first 1,0,1,1,0,0,1,0 back-to-back
    exp_q0.push_back({1'b0, 8'hB2});
    send_seq(0, 8'hB2, 16'h0);
    chk("t2_out_valid", {8'h0, out_valid[0]}, 9'h1);
    chk("t2_out_word",  {out_and[0], ow[0]}, {1'b0, 8'hB2});
    chk("t2_bit_count", {5'h0, bc[0]}, 9'h8);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("t2_in_ready_after", {8'h0, in_ready[0]}, 9'h1);

    // T3 eight 1s with gaps, held 5 cycles with extra input ignored
    exp_q0.push_back({1'b1, 8'hFF});
    send_seq(0, 8'hFF, 16'b01_00_11_00_10_01_00_10);
    for (int unsigned c = 0; c < 5; c++) begin
      in_valid[0] = 1'b1;
      in_bit[0]   = c[0];
      tick();
      chk("t3_hold_word", {out_and[0], ow[0]}, {1'b1, 8'hFF});
      chk("t3_hold_ready", {7'h0, in_ready[0], out_valid[0]}, 9'h1);
      chk("t3_hold_count", {5'h0, bc[0]}, 9'h8);
    end
    in_valid[0] = 1'b0;
    in_bit[0]   = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("t3_release_state", {7'h0, in_ready[0], out_valid[0]}, 9'h2);
    chk("t3_release_count", {5'h0, bc[0]}, 9'h0);
    chk("t3_word_kept", {out_and[0], ow[0]}, {1'b1, 8'hFF});

    // T4 LSB-first: first bit lands in bit 0; then 0xA5 with out_ready held high
    exp_q1.push_back({1'b0, 8'h01});
    send_seq(1, 8'h80, 16'h0);
    chk("t4_word_01", {out_and[1], ow[1]}, {1'b0, 8'h01});
    out_ready[1] = 1'b1;
    tick();
    exp_q1.push_back({1'b0, 8'hA5});
    send_seq(1, 8'hA5, 16'h0);
    chk("t4_word_a5", {out_and[1], ow[1]}, {1'b0, 8'hA5});
    chk("t4_valid_a5", {8'h0, out_valid[1]}, 9'h1);
    tick();
    out_ready[1] = 1'b0;
    chk("t4_consumed", {8'h0, out_valid[1]}, 9'h0);

    // T5 clear after 5 bits (with a same-cycle bit discarded), then 0x3C
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1; in_bit[0] = 1'b1;
      tick();
    end
    chk("t5_partial_count", {5'h0, bc[0]}, 9'h5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid[0] = 1'b0; in_bit[0] = 1'b0;
    chk("t5_cleared_count", {5'h0, bc[0]}, 9'h0);
    exp_q0.push_back({1'b0, 8'h3C});
    send_seq(0, 8'h3C, 16'h0);
    chk("t5_word", {out_and[0], ow[0]}, {1'b0, 8'h3C});
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;

    // Clear in HOLD with out_ready: word dropped, outputs keep last value
    send_seq(1, 8'hFF, 16'h0);
    chk("clr_hold_valid", {8'h0, out_valid[1]}, 9'h1);
    clear = 1'b1; out_ready[1] = 1'b1;
    tick();
    clear = 1'b0; out_ready[1] = 1'b0;
    chk("clr_hold_drop", {7'h0, in_ready[1], out_valid[1]}, 9'h2);
    chk("clr_hold_word", {out_and[1], ow[1]}, {1'b1, 8'hFF});

    // T6 reset in HOLD with out_ready in the same cycle
    send_seq(0, 8'hFF, 16'h0);
    chk("t6_hold", {8'h0, out_valid[0]}, 9'h1);
    reset = 1'b1; out_ready[0] = 1'b1;
    tick();
    reset = 1'b0; out_ready[0] = 1'b0;
    chk("t6_out_valid", {8'h0, out_valid[0]}, 9'h0);
    chk("t6_out_word", {out_and[0], ow[0]}, 9'h000);
    chk("t6_bit_count", {5'h0, bc[0]}, 9'h0);
    tick(); tick();

    chk("msb_queue_empty", 9'(exp_q0.size()), 9'h0);
    chk("lsb_queue_empty", 9'(exp_q1.size()), 9'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
